// File: rtl/mips_bus_arbiter.sv
// Two-requester bus arbiter: serialises instruction-fetch and load/store transfers
// onto one waitrequest-style memory bus, alternating grants under contention.
module mips_bus_arbiter #(
    parameter int MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    localparam logic [31:0] WAIT_LIMIT = 32'(MAX_WAIT);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        isWrite_q, isWrite_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] waitCnt_q, waitCnt_d;
    logic        busErr_q, busErr_d;
    logic        grantData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            owner_q   <= 1'b0;
            isWrite_q <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            waitCnt_q <= 32'h0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            waitCnt_q <= waitCnt_d;
            busErr_q  <= busErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        waitCnt_d = waitCnt_q;
        busErr_d  = busErr_q;
        // With both pending, data wins only if fetch was served last.
        grantData = d_req && (!i_req || !last_q);
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d   = grantData;
                    last_d    = grantData;
                    isWrite_d = grantData && d_write;
                    addr_d    = grantData ? d_addr : i_addr;
                    wdata_d   = grantData ? d_wdata : 32'h0;
                    be_d      = grantData ? d_byteen : 4'hF;
                    waitCnt_d = 32'h0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (waitrequest) begin
                    if (waitCnt_q != 32'hFFFF_FFFF) begin
                        waitCnt_d = waitCnt_q + 32'd1;
                    end
                    // Flag on the wait cycle that brings the count up to the limit.
                    if ((MAX_WAIT > 0) && (waitCnt_q >= WAIT_LIMIT - 32'd1)) begin
                        busErr_d = 1'b1;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read       = (state_q == ISSUE) && !isWrite_q;
    assign write      = (state_q == ISSUE) && isWrite_q;
    assign i_ack      = (state_q == DONE) && !owner_q;
    assign d_ack      = (state_q == DONE) && owner_q;
    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign bus_err    = busErr_q;
    assign i_rdata    = readdata;
    assign d_rdata    = readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: directed requests against a small RAM
// model with programmable waitrequest stalls; acks are checked by a monitor.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        bus_err;

    mips_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteen(d_byteen), .d_ack(d_ack), .d_rdata(d_rdata),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        bit          chkData;
        logic [31:0] data;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          ackCount = 0;
    int          stallCfg = 0;
    int          stallCnt = 0;
    logic [31:0] mem [0:255];

    assign waitrequest = (read || write) && (stallCnt < stallCfg);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // RAM model: stalls each strobe for stallCfg cycles, read data lands next cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h2402_0005;
        mem[8'h40] = 32'h1122_3344;
        mem[8'h80] = 32'hA000_0001;
        mem[8'hC0] = 32'hD000_0002;
        readdata = 32'h0;
        forever begin
            @(posedge clk);
            if (read || write) begin
                if (waitrequest) begin
                    stallCnt <= stallCnt + 1;
                end else begin
                    stallCnt <= 0;
                    if (read) begin
                        readdata <= mem[address[9:2]];
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (byteenable[b]) mem[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end else begin
                stallCnt <= 0;
            end
        end
    end

    // Monitor: pops one expectation per ack pulse and checks owner and data.
    initial begin
        exp_t e;
        logic prevAck;
        prevAck = 1'b0;
        forever begin
            @(negedge clk);
            checkOutput("rw_exclusive", {31'b0, read & write}, 32'h0);
            if (i_ack || d_ack) begin
                checkOutput("ack_exclusive", {31'b0, i_ack & d_ack}, 32'h0);
                checkOutput("ack_one_cycle", {31'b0, prevAck}, 32'h0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack_owner", {31'b0, d_ack}, {31'b0, e.isData});
                    if (e.chkData) begin
                        if (e.isData) checkOutput("d_rdata", d_rdata, e.data);
                        else          checkOutput("i_rdata", i_rdata, e.data);
                    end
                end
                ackCount++;
            end
            prevAck = i_ack | d_ack;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit iReq, input logic [31:0] iAddr, input bit dReq,
                                 input bit dWrite, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic [3:0] dBe);
        i_req    = iReq;
        i_addr   = iAddr;
        d_req    = dReq;
        d_write  = dWrite;
        d_addr   = dAddr;
        d_wdata  = dWdata;
        d_byteen = dBe;
    endtask

    task automatic waitAcks(input int target, input int budget, input string name,
                            output int cycles);
        cycles = 0;
        while (ackCount < target && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput(name, ackCount, target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_read"}, {31'b0, read}, 32'h0);
        checkOutput({tag, "_write"}, {31'b0, write}, 32'h0);
        checkOutput({tag, "_address"}, address, 32'h0);
        checkOutput({tag, "_writedata"}, writedata, 32'h0);
        checkOutput({tag, "_byteenable"}, {28'b0, byteenable}, 32'h0);
        checkOutput({tag, "_i_ack"}, {31'b0, i_ack}, 32'h0);
        checkOutput({tag, "_d_ack"}, {31'b0, d_ack}, 32'h0);
        checkOutput({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1;
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Uncontended fetch
        applyStimulus(1, 32'hBFC0_0000, 0, 0, 32'h0, 32'h0, 4'h0);
        expQ.push_back(exp_t'{1'b0, 1'b1, 32'h2402_0005});
        @(negedge clk);
        checkOutput("fetch_no_early_read", {31'b0, read}, 32'h0);
        @(negedge clk);
        checkOutput("fetch_read", {31'b0, read}, 32'h1);
        checkOutput("fetch_address", address, 32'hBFC0_0000);
        checkOutput("fetch_byteenable", {28'b0, byteenable}, 32'hF);
        checkOutput("fetch_writedata", writedata, 32'h0);
        waitAcks(1, 10, "fetch_ack_seen", n);
        checkOutput("fetch_ack_latency", n, 1);
        @(posedge clk); #1;

        // Store with three stall cycles
        applyStimulus(0, 32'h0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        stallCfg = 3;
        expQ.push_back(exp_t'{1'b1, 1'b0, 32'h0});
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("store_write%0d", k), {31'b0, write}, 32'h1);
            checkOutput($sformatf("store_read%0d", k), {31'b0, read}, 32'h0);
            checkOutput($sformatf("store_addr%0d", k), address, 32'h100);
            checkOutput($sformatf("store_wdata%0d", k), writedata, 32'hDEAD_BEEF);
            checkOutput($sformatf("store_be%0d", k), {28'b0, byteenable}, 32'h3);
        end
        waitAcks(2, 5, "store_ack_seen", n);
        checkOutput("store_ack_latency", n, 1);
        checkOutput("store_ram_word", mem[8'h40], 32'h1122_BEEF);
        checkOutput("store_no_bus_err", {31'b0, bus_err}, 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of a stalled fetch
        applyStimulus(1, 32'h200, 0, 0, 32'h0, 32'h0, 4'h0);
        stallCfg = 3;
        @(posedge clk); #1;
        checkOutput("abort_read_before", {31'b0, read}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("abort_no_i_ack", {31'b0, i_ack}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        stallCfg = 0;

        // Contention from reset: data, fetch, data, fetch
        base = ackCount;
        applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'hF);
        expQ.push_back(exp_t'{1'b1, 1'b1, 32'hD000_0002});
        expQ.push_back(exp_t'{1'b0, 1'b1, 32'hA000_0001});
        expQ.push_back(exp_t'{1'b1, 1'b1, 32'hD000_0002});
        expQ.push_back(exp_t'{1'b0, 1'b1, 32'hA000_0001});
        waitAcks(base + 4, 20, "contend_acks", n);
        checkOutput("contend_total_cycles", n, 12);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

        // Fetch request arriving during a stalled load
        base = ackCount;
        stallCfg = 2;
        applyStimulus(0, 32'h0, 1, 0, 32'h300, 32'h0, 4'hF);
        expQ.push_back(exp_t'{1'b1, 1'b1, 32'hD000_0002});
        expQ.push_back(exp_t'{1'b0, 1'b1, 32'hA000_0001});
        @(posedge clk); #1;
        checkOutput("late_data_read", {31'b0, read}, 32'h1);
        i_req  = 1'b1;
        i_addr = 32'h200;
        waitAcks(base + 1, 10, "late_d_ack_seen", n);
        checkOutput("late_data_latency", n, 4);
        @(posedge clk); #1;
        d_req = 1'b0;
        stallCfg = 0;
        checkOutput("late_idle_no_read", {31'b0, read}, 32'h0);
        @(posedge clk); #1;
        checkOutput("late_fetch_read", {31'b0, read}, 32'h1);
        checkOutput("late_fetch_addr", address, 32'h200);
        waitAcks(base + 2, 10, "late_i_ack_seen", n);
        checkOutput("late_fetch_latency", n, 2);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Wait limit: error after the fourth stall, transfer still completes
        base = ackCount;
        stallCfg = 10;
        applyStimulus(1, 32'h200, 0, 0, 32'h0, 32'h0, 4'h0);
        expQ.push_back(exp_t'{1'b0, 1'b1, 32'hA000_0001});
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("werr_wait%0d", k), {31'b0, bus_err}, {31'b0, (k >= 5)});
            checkOutput($sformatf("werr_read%0d", k), {31'b0, read}, 32'h1);
        end
        waitAcks(base + 1, 5, "werr_ack_seen", n);
        checkOutput("werr_ack_latency", n, 2);
        @(posedge clk); #1;
        i_req = 1'b0;
        stallCfg = 0;
        repeat (3) @(negedge clk);
        checkOutput("werr_sticky", {31'b0, bus_err}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("werr_cleared_by_reset", {31'b0, bus_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("queue_empty", expQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
